wb_periph_bus: RTL and testbench

- Parametrised Wishbone peripheral bridge between the CPU data-bus Wishbone master (after cache/RAM split) and WB_N single-cycle peripherals (HyperRAM ctrl cfg, UART, platform, RGB, ...).
- Registered address decode and per-slave cyc fan-out; shared addr/wdata/wmsk/we; rdata/ack mux.
- Adds a bus timeout and an unmapped-slave error response, both signalled on up_err.

---
 rtl/wb_periph_bus_pkg.sv | 19 +
 rtl/wb_periph_bus_mux.sv | 26 ++
 rtl/wb_periph_bus.sv | 184 ++++++++++++++++++
 tb/tb_wb_periph_bus.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_periph_bus_pkg.sv
// Shared definitions for the Wishbone peripheral bridge: FSM encoding,
// slot-select width helper and the default bus timeout.
package wb_periph_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } wb_state_e;

  localparam int WB_TIMEOUT_DEF = 255;
  localparam int WB_ERR_CNT_W   = 8;

  // Slot-select field width; a single slot still gets one select bit.
  function automatic int wb_sw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_periph_bus_mux.sv
// WB_N-way read-data / ack select by slot index. Acks from any other
// slot are simply not looked at.
module wb_periph_bus_mux #(
  parameter int WB_N  = 4,
  parameter int WB_DW = 32,
  parameter int SW    = 2
) (
  input  logic [WB_N*WB_DW-1:0] rdata_flat_i,
  input  logic [WB_N-1:0]       ack_i,
  input  logic [SW-1:0]         slot_i,
  output logic [WB_DW-1:0]      rdata_o,
  output logic                  ack_o
);

  always_comb begin
    rdata_o = '0;
    ack_o   = 1'b0;
    for (int i = 0; i < WB_N; i++) begin
      if (slot_i == SW'(i)) begin
        rdata_o = rdata_flat_i[i*WB_DW +: WB_DW];
        ack_o   = ack_i[i];
      end
    end
  end

endmodule

// File: rtl/wb_periph_bus.sv
// Wishbone bridge from the CPU data bus to WB_N single-cycle peripherals,
// with bus timeout and unmapped-slot error. Error log: WB_PERIPH_BUS_ERRLOG_EN.
module wb_periph_bus
  import wb_periph_bus_pkg::*;
#(
  parameter  int WB_N    = 4,
  parameter  int WB_DW   = 32,
  parameter  int WB_AW   = 22,
  parameter  int TIMEOUT = WB_TIMEOUT_DEF,
  localparam int SW      = wb_sw(WB_N),
  localparam int MW      = WB_DW / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    up_cyc,
  input  logic                    up_stb,
  input  logic                    up_we,
  input  logic [WB_AW+SW-1:0]     up_adr,
  input  logic [WB_DW-1:0]        up_wdata,
  input  logic [MW-1:0]           up_sel,
  output logic [WB_DW-1:0]        up_rdata,
  output logic                    up_ack,
  output logic                    up_err,
  output logic [WB_AW-1:0]        wb_addr,
  output logic [WB_DW-1:0]        wb_wdata,
  output logic [MW-1:0]           wb_wmsk,
  output logic                    wb_we,
  output logic [WB_N-1:0]         wb_cyc,
  input  logic [WB_DW*WB_N-1:0]   wb_rdata,
  input  logic [WB_N-1:0]         wb_ack,
  output logic [WB_ERR_CNT_W-1:0] err_cnt,
  output logic [WB_AW+SW-1:0]     err_addr
);

  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [SW:0]     N_SLOTS  = (SW+1)'(WB_N);

  wb_state_e          state_q, state_d;
  logic [SW-1:0]      slot_q, slot_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WB_N-1:0]    cyc_q, cyc_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [WB_DW-1:0]   rdata_q, rdata_d;
  logic [WB_AW-1:0]   addr_q, addr_d;
  logic [WB_DW-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]      wmsk_q, wmsk_d;
  logic               we_q, we_d;

  logic [SW-1:0]      req_slot;
  logic               req_mapped;
  logic [WB_DW-1:0]   sel_rdata;
  logic               sel_ack;

  assign req_slot   = up_adr[WB_AW +: SW];
  assign req_mapped = ({1'b0, req_slot} < N_SLOTS);

  wb_periph_bus_mux #(
    .WB_N  (WB_N),
    .WB_DW (WB_DW),
    .SW    (SW)
  ) u_mux (
    .rdata_flat_i (wb_rdata),
    .ack_i        (wb_ack),
    .slot_i       (slot_q),
    .rdata_o      (sel_rdata),
    .ack_o        (sel_ack)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmsk_d  = wmsk_q;
    we_d    = we_q;
    unique case (state_q)
      ST_IDLE: begin
        if (up_cyc && up_stb) begin
          addr_d  = up_adr[WB_AW-1:0];
          wdata_d = up_wdata;
          wmsk_d  = up_sel;
          we_d    = up_we;
          slot_d  = req_slot;
          if (req_mapped) begin
            state_d = ST_ACCESS;
            cyc_d   = WB_N'(1) << req_slot;
            cnt_d   = '0;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        // A master that walks away gets no response at all.
        if (!up_cyc) begin
          cyc_d   = '0;
          state_d = ST_IDLE;
        end else if (sel_ack) begin
          rdata_d = sel_rdata;
          cyc_d   = '0;
          ack_d   = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          cyc_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmsk_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmsk_q  <= wmsk_d;
      we_q    <= we_d;
    end
  end

  assign up_rdata = rdata_q;
  assign up_ack   = ack_q;
  assign up_err   = err_q;
  assign wb_addr  = addr_q;
  assign wb_wdata = wdata_q;
  assign wb_wmsk  = wmsk_q;
  assign wb_we    = we_q;
  assign wb_cyc   = cyc_q;

`ifdef WB_PERIPH_BUS_ERRLOG_EN
  logic [WB_ERR_CNT_W-1:0] err_cnt_q;
  logic [WB_AW+SW-1:0]     err_addr_q;

  // Unmapped faults come straight from the request; timeouts from the latched one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else if (err_d) begin
      if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
      err_addr_q <= (state_q == ST_IDLE) ? up_adr : {slot_q, addr_q};
    end
  end

  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;
`else
  assign err_cnt  = '0;
  assign err_addr = '0;
`endif

endmodule

// File: tb/tb_wb_periph_bus.sv
// Randomized scoreboard bench for wb_periph_bus (3 slots, so slot 3 is
// unmapped; short timeout of 8).
module tb_wb_periph_bus;

  localparam int N     = 3;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int TO    = 8;
  localparam int SW    = 2;
  localparam int AWU   = AW + SW;
  localparam int NEVER = 1000;

  logic              clk, rst;
  logic              up_cyc, up_stb, up_we;
  logic [AWU-1:0]    up_adr;
  logic [DW-1:0]     up_wdata, up_rdata;
  logic [3:0]        up_sel;
  logic              up_ack, up_err;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_wdata;
  logic [3:0]        wb_wmsk;
  logic              wb_we;
  logic [N-1:0]      wb_cyc, wb_ack;
  logic [N*DW-1:0]   wb_rdata;
  logic [7:0]        err_cnt;
  logic [AWU-1:0]    err_addr;

  wb_periph_bus #(.WB_N(N), .WB_DW(DW), .WB_AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .up_cyc(up_cyc), .up_stb(up_stb), .up_we(up_we),
    .up_adr(up_adr), .up_wdata(up_wdata), .up_sel(up_sel), .up_rdata(up_rdata),
    .up_ack(up_ack), .up_err(up_err), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
    .wb_wmsk(wb_wmsk), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_rdata(wb_rdata),
    .wb_ack(wb_ack), .err_cnt(err_cnt), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Slave model: slot i acks once wb_cyc[i] has been seen high for more than
  // dly[i] cycles; idle slots throw random acks that must be ignored.
  int            dly [N];
  int            age [N];
  logic [DW-1:0] srd [N];
  logic [N-1:0]  noise;

  initial begin
    for (int i = 0; i < N; i++) begin dly[i] = NEVER; age[i] = 0; srd[i] = '0; end
    noise = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) age[i] = wb_cyc[i] ? age[i] + 1 : 0;
      noise = N'($urandom);
    end
  end

  always_comb begin
    wb_ack   = '0;
    wb_rdata = '0;
    for (int i = 0; i < N; i++) begin
      wb_ack[i] = (wb_cyc[i] && age[i] > dly[i]) || (noise[i] && !wb_cyc[i]);
      wb_rdata[i*DW +: DW] = srd[i];
    end
  end

  typedef struct {
    logic           is_err;
    logic           chk_rd;
    logic [DW-1:0]  rd;
    int             edge_n;
    logic [AWU-1:0] adr;
  } resp_t;

  typedef struct {
    logic [N-1:0]  cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [3:0]    msk;
    logic          we;
    int            edge_n;
    int            dur;
  } cyc_t;

  resp_t rq[$];
  cyc_t  cq[$];

  // Monitor: every upstream response and every downstream cycle is matched
  // against the head of its queue.
  initial begin
    logic [N-1:0]   prev_cyc;
    int             rise_n, exp_dur, exp_ecnt;
    logic [AWU-1:0] exp_eadr;
    resp_t r;
    cyc_t  c;
    prev_cyc = '0; rise_n = 0; exp_dur = -1; exp_ecnt = 0; exp_eadr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cyc = '0; exp_dur = -1; exp_ecnt = 0; exp_eadr = '0;
      end else begin
        if (up_ack || up_err) begin
          if (rq.size() == 0) chk("resp_unexpected", {up_ack, up_err}, 2'b00);
          else begin
            r = rq.pop_front();
            chk("resp_err", up_err, r.is_err);
            chk("resp_ack", up_ack, !r.is_err);
            chk("resp_cycle", cyc_n, r.edge_n);
            if (r.chk_rd) chk("resp_rdata", up_rdata, r.rd);
            if (r.is_err) begin
              if (exp_ecnt < 255) exp_ecnt++;
              exp_eadr = r.adr;
            end
`ifdef WB_PERIPH_BUS_ERRLOG_EN
            chk("err_cnt", err_cnt, exp_ecnt);
            chk("err_addr", err_addr, exp_eadr);
`else
            chk("err_cnt", err_cnt, 0);
            chk("err_addr", err_addr, 0);
`endif
          end
        end
        if (wb_cyc != '0 && prev_cyc == '0) begin
          if (cq.size() == 0) chk("cyc_unexpected", wb_cyc, 0);
          else begin
            c = cq.pop_front();
            chk("cyc_onehot", wb_cyc, c.cyc);
            chk("cyc_addr", wb_addr, c.addr);
            chk("cyc_wdata", wb_wdata, c.wd);
            chk("cyc_wmsk", wb_wmsk, c.msk);
            chk("cyc_we", wb_we, c.we);
            chk("cyc_start", cyc_n, c.edge_n);
            rise_n  = cyc_n;
            exp_dur = c.dur;
          end
        end
        if (wb_cyc == '0 && prev_cyc != '0 && exp_dur >= 0) begin
          chk("cyc_len", cyc_n - rise_n, exp_dur);
          exp_dur = -1;
        end
        prev_cyc = wb_cyc;
      end
    end
  end

  task automatic chk_zero_all(input string tag);
    chk({tag, "_up_ack"}, up_ack, 0);
    chk({tag, "_up_err"}, up_err, 0);
    chk({tag, "_up_rdata"}, up_rdata, 0);
    chk({tag, "_wb_addr"}, wb_addr, 0);
    chk({tag, "_wb_wdata"}, wb_wdata, 0);
    chk({tag, "_wb_wmsk"}, wb_wmsk, 0);
    chk({tag, "_wb_we"}, wb_we, 0);
    chk({tag, "_wb_cyc"}, wb_cyc, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_err_addr"}, err_addr, 0);
  endtask

  // One master transaction; abort_j >= 0 drops up_cyc that many cycles
  // after wb_cyc rises, instead of waiting for a response.
  task automatic issue(input logic we, input int slot, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [3:0] sel,
                       input int d, input logic [DW-1:0] rdv, input int abort_j);
    resp_t r;
    cyc_t  c;
    int    acc, w;
    logic  mapped;
    logic [AWU-1:0] adr;
    adr    = {slot[SW-1:0], a};
    mapped = (slot < N);
    for (int i = 0; i < N; i++) srd[i] = $urandom;
    if (mapped) begin srd[slot] = rdv; dly[slot] = d; end
    up_cyc = 1'b1; up_stb = 1'b1; up_we = we; up_adr = adr; up_wdata = wd; up_sel = sel;
    @(posedge clk); #1;
    acc = cyc_n;
    r.adr = adr; r.rd = '0; r.chk_rd = 1'b0; r.is_err = 1'b1; r.edge_n = acc;
    if (mapped) begin
      c.cyc = N'(1) << slot; c.addr = a; c.wd = wd; c.msk = sel; c.we = we;
      c.edge_n = acc;
      if (abort_j >= 0) c.dur = abort_j + 1;
      else if (d >= TO) begin
        c.dur = TO; r.edge_n = acc + TO; r.chk_rd = 1'b1;
      end else begin
        c.dur = d + 1; r.edge_n = acc + d + 1; r.is_err = 1'b0;
        r.rd = rdv; r.chk_rd = !we;
      end
      cq.push_back(c);
    end
    if (abort_j < 0 || !mapped) rq.push_back(r);
    @(negedge clk);
    up_stb = 1'b0;
    if (mapped && abort_j >= 0) begin
      repeat (abort_j) @(negedge clk);
      up_cyc = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      w = 0;
      while (!(up_ack || up_err) && w < 40) begin @(negedge clk); w++; end
      if (w >= 40) chk("resp_wait", {up_ack, up_err}, 2'b11);
      up_cyc = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    cyc_t c;
    int r, d, j;
    rst = 1'b1; up_cyc = 1'b0; up_stb = 1'b0; up_we = 1'b0;
    up_adr = '0; up_wdata = '0; up_sel = '0;
    #23;
    chk_zero_all("reset");
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 1, 8'h10, 32'h0, 4'hF, 0, 32'hDEADBEEF, -1);
    issue(1'b1, 2, 8'h44, 32'h12345678, 4'b0011, 3, 32'h0, -1);
    issue(1'b0, 3, 8'h5A, 32'h0, 4'hF, 0, 32'h0, -1);
    issue(1'b0, 2, 8'h20, 32'h0, 4'hF, NEVER, 32'hCAFEF00D, -1);
    issue(1'b0, 0, 8'h21, 32'h0, 4'hF, TO - 1, 32'hA5A5A5A5, -1);
    issue(1'b0, 1, 8'h22, 32'h0, 4'hF, TO, 32'h5A5A5A5A, -1);
    issue(1'b0, 0, 8'h23, 32'h0, 4'hF, NEVER, 32'h0, 2);

    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      j = -1;
      if (r <= 5) d = r;
      else if (r == 6) d = TO - 1;
      else if (r == 7) d = TO;
      else d = NEVER;
      if (r == 9) j = $urandom_range(0, 5);
      issue(1'($urandom), (j >= 0) ? $urandom_range(0, N - 1) : $urandom_range(0, 3),
            AW'($urandom), $urandom, 4'($urandom), d, $urandom, j);
    end

    for (int k = 0; k < 300; k++)
      issue(1'($urandom), 3, AW'($urandom), $urandom, 4'hF, 0, 32'h0, -1);

    // Asynchronous reset in the middle of an access.
    for (int i = 0; i < N; i++) srd[i] = $urandom;
    dly[1] = NEVER;
    up_cyc = 1'b1; up_stb = 1'b1; up_we = 1'b1;
    up_adr = {2'd1, 8'h33}; up_wdata = 32'h0BADF00D; up_sel = 4'b1100;
    @(posedge clk); #1;
    c.cyc = 3'b010; c.addr = 8'h33; c.wd = 32'h0BADF00D; c.msk = 4'b1100; c.we = 1'b1;
    c.edge_n = cyc_n; c.dur = -1;
    cq.push_back(c);
    @(negedge clk); up_stb = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero_all("rst_mid");
    up_cyc = 1'b0;
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 0, 8'h77, 32'h0, 4'hF, 1, 32'h13572468, -1);
    issue(1'b0, 3, 8'h78, 32'h0, 4'hF, 0, 32'h0, -1);

    repeat (4) @(negedge clk);
    chk("rq_drained", rq.size(), 0);
    chk("cq_drained", cq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
